// File: rtl/msx2_ram_mapper_bridge_pkg.sv
// Shared types and constants for the MSX2 RAM mapper bridge.
package msx2_ram_mapper_bridge_pkg;

    localparam int unsigned SEG_OFFSET_W = 14;
    localparam int unsigned SEG_W        = 8;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned CPU_ADDR_W   = 16;
    localparam int unsigned TIMER_W      = 8;

    // Value the CPU sees on an undriven data bus.
    localparam logic [DATA_W-1:0] OPEN_BUS = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mapper_bridge_state_t;

    // A size of zero stands for a full 256-segment mapper.
    function automatic logic seg_in_range(input logic [SEG_W-1:0] seg,
                                          input logic [SEG_W-1:0] size);
        return (size == '0) || (seg < size);
    endfunction

endpackage

// File: rtl/msx2_ram_mapper_bridge_if.sv
// CPU-side and RAM-side bus signals of the mapper bridge.
interface msx2_ram_mapper_bridge_if
    import msx2_ram_mapper_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 22
);
    // CPU / slot side
    logic                     mem_rq;
    logic                     rd;
    logic                     wr;
    logic [CPU_ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]        wdata;
    logic [SEG_W-1:0]         segment;
    logic [SEG_W-1:0]         size;
    logic                     cpu_wait;
    logic [DATA_W-1:0]        rdata;
    logic                     rdata_valid;
    // RAM controller side
    logic                     ram_req;
    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_wdata;
    logic                     ram_ack;
    logic [DATA_W-1:0]        ram_rdata;
    // Status
    logic                     timeout_err;

    // Bridge side
    modport slave (
        input  mem_rq, rd, wr, addr, wdata, segment, size, ram_ack, ram_rdata,
        output cpu_wait, rdata, rdata_valid, ram_req, ram_we, ram_addr,
               ram_wdata, timeout_err
    );

    // Environment side (CPU, register block and RAM controller)
    modport master (
        output mem_rq, rd, wr, addr, wdata, segment, size, ram_ack, ram_rdata,
        input  cpu_wait, rdata, rdata_valid, ram_req, ram_we, ram_addr,
               ram_wdata, timeout_err
    );

endinterface

// File: rtl/msx2_ram_req_timer.sv
// Counts cycles spent waiting for ram_ack and flags the last allowed cycle.
module msx2_ram_req_timer
    import msx2_ram_mapper_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_c = (count_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/msx2_ram_mapper_bridge.sv
// Turns a mapped CPU memory cycle into one RAM req/ack transaction,
// stretching the CPU with wait and holding read data for the data mux.
module msx2_ram_mapper_bridge
    import msx2_ram_mapper_bridge_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 22,
    parameter logic [ADDR_W-1:0]  RAM_BASE = '0,
    parameter int unsigned        TIMEOUT  = 255
) (
    input  logic                        clk,
    input  logic                        reset_n,
    msx2_ram_mapper_bridge_if.slave     bus
);

    mapper_bridge_state_t state_q, state_d;
    logic                 ram_req_q, ram_req_d;
    logic                 ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 rdata_valid_q, rdata_valid_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 start_c;
    logic                 we_c;
    logic                 in_range_c;
    logic [ADDR_W-1:0]    mapped_addr_c;
    logic                 timer_clr_c;
    logic                 timer_en_c;
    logic                 timer_expire_c;
    logic                 unused_bank_c;

    // addr[15:14] already selected the segment upstream.
    assign unused_bank_c = ^bus.addr[CPU_ADDR_W-1:SEG_OFFSET_W];

    // Access decode; a simultaneous rd and wr is treated as a read.
    assign start_c    = (state_q == IDLE) && bus.mem_rq && (bus.rd || bus.wr);
    assign we_c       = bus.wr && !bus.rd;
    assign in_range_c = seg_in_range(bus.segment, bus.size);

    // Physical address wraps modulo 2^ADDR_W.
    assign mapped_addr_c = RAM_BASE
                         + ADDR_W'({bus.segment, bus.addr[SEG_OFFSET_W-1:0]});

    msx2_ram_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset_n),
        .clr      (timer_clr_c),
        .en       (timer_en_c),
        .expire_c (timer_expire_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        ram_req_d     = ram_req_q;
        ram_we_d      = ram_we_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        timeout_err_d = timeout_err_q;
        timer_clr_c   = 1'b0;
        timer_en_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    ram_we_d    = we_c;
                    ram_addr_d  = mapped_addr_c;
                    ram_wdata_d = bus.wdata;
                    if (in_range_c) begin
                        state_d   = REQ;
                        ram_req_d = 1'b1;
                    end else begin
                        // Unpopulated segment: reads float, writes vanish.
                        state_d = DONE;
                        if (!we_c) begin
                            rdata_d       = OPEN_BUS;
                            rdata_valid_d = 1'b1;
                        end
                    end
                end
            end

            REQ: begin
                if (bus.ram_ack) begin
                    state_d   = DONE;
                    ram_req_d = 1'b0;
                    if (!ram_we_q) begin
                        rdata_d       = bus.ram_rdata;
                        rdata_valid_d = 1'b1;
                    end
                end else if (timer_expire_c) begin
                    state_d       = DONE;
                    ram_req_d     = 1'b0;
                    rdata_d       = OPEN_BUS;
                    rdata_valid_d = !ram_we_q;
                    timeout_err_d = 1'b1;
                end else begin
                    timer_en_c = 1'b1;
                end
            end

            DONE: begin
                // Wait for the CPU cycle to end so a held mem_rq cannot re-trigger.
                if (!bus.mem_rq) begin
                    state_d       = IDLE;
                    rdata_valid_d = 1'b0;
                    timer_clr_c   = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                ram_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ram_req_q     <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            rdata_q       <= OPEN_BUS;
            rdata_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ram_req_q     <= ram_req_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Wait is combinational so the CPU is stalled in the very cycle it starts.
    assign bus.cpu_wait    = reset_n && (start_c || (state_q == REQ));
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.ram_req     = ram_req_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_msx2_ram_mapper_bridge.sv
// Directed bench for the MSX2 RAM mapper bridge.
module tb_msx2_ram_mapper_bridge;

    logic clk = 1'b0;
    logic reset_n;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    msx2_ram_mapper_bridge_if #(.ADDR_W(22)) bus_a ();
    msx2_ram_mapper_bridge_if #(.ADDR_W(22)) bus_b ();

    // Zero base, short timeout
    msx2_ram_mapper_bridge #(
        .ADDR_W   (22),
        .RAM_BASE (22'h000000),
        .TIMEOUT  (4)
    ) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    // High base to exercise address wrap
    msx2_ram_mapper_bridge #(
        .ADDR_W   (22),
        .RAM_BASE (22'h3F0000),
        .TIMEOUT  (255)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_a();
        bus_a.mem_rq = 1'b0; bus_a.rd = 1'b0; bus_a.wr = 1'b0; bus_a.ram_ack = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        bus_a.mem_rq = 1'b1; bus_a.rd = 1'b1;
        #1;
        tests_run++; if (bus_a.cpu_wait !== 1'b0) begin tests_failed++; $display("FAIL reset_cpu_wait got %b want 0", bus_a.cpu_wait); end
        tests_run++; if (bus_a.rdata !== 8'hFF) begin tests_failed++; $display("FAIL reset_rdata got %h want FF", bus_a.rdata); end
        tests_run++; if (bus_a.rdata_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rdata_valid got %b want 0", bus_a.rdata_valid); end
        tests_run++; if (bus_a.ram_req !== 1'b0) begin tests_failed++; $display("FAIL reset_ram_req got %b want 0", bus_a.ram_req); end
        tests_run++; if (bus_a.ram_we !== 1'b0) begin tests_failed++; $display("FAIL reset_ram_we got %b want 0", bus_a.ram_we); end
        tests_run++; if (bus_a.ram_addr !== 22'h0) begin tests_failed++; $display("FAIL reset_ram_addr got %h want 0", bus_a.ram_addr); end
        tests_run++; if (bus_a.ram_wdata !== 8'h00) begin tests_failed++; $display("FAIL reset_ram_wdata got %h want 00", bus_a.ram_wdata); end
        tests_run++; if (bus_a.timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout_err got %b want 0", bus_a.timeout_err); end
        bus_a.mem_rq = 1'b0; bus_a.rd = 1'b0;
    endtask

    task automatic test_read();
        int waits;
        int reqs;
        bus_a.segment = 8'h03; bus_a.addr = 16'h8123; bus_a.size = 8'h08;
        bus_a.rd = 1'b1; bus_a.wr = 1'b0; bus_a.mem_rq = 1'b1;
        #1;
        waits = bus_a.cpu_wait ? 1 : 0;
        reqs  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus_a.ram_ack = 1'b0;
            #1;
            if (!bus_a.cpu_wait) break;
            waits++;
            if (bus_a.ram_req) begin
                reqs++;
                if (reqs == 1) begin
                    tests_run++; if (bus_a.ram_addr !== 22'h00C123) begin tests_failed++; $display("FAIL read_ram_addr got %h want 00C123", bus_a.ram_addr); end
                    tests_run++; if (bus_a.ram_we !== 1'b0) begin tests_failed++; $display("FAIL read_ram_we got %b want 0", bus_a.ram_we); end
                end
                if (reqs == 3) begin
                    bus_a.ram_rdata = 8'h5A;
                    bus_a.ram_ack   = 1'b1;
                end
            end
        end
        tests_run++; if (waits != 4) begin tests_failed++; $display("FAIL read_wait_cycles got %0d want 4", waits); end
        tests_run++; if (reqs != 3) begin tests_failed++; $display("FAIL read_req_cycles got %0d want 3", reqs); end
        tests_run++; if (bus_a.rdata !== 8'h5A) begin tests_failed++; $display("FAIL read_rdata got %h want 5A", bus_a.rdata); end
        tests_run++; if (bus_a.rdata_valid !== 1'b1) begin tests_failed++; $display("FAIL read_rdata_valid got %b want 1", bus_a.rdata_valid); end
        repeat (3) tick();
        tests_run++; if (bus_a.rdata_valid !== 1'b1 || bus_a.rdata !== 8'h5A) begin tests_failed++; $display("FAIL read_hold got valid=%b rdata=%h want 1/5A", bus_a.rdata_valid, bus_a.rdata); end
        bus_a.mem_rq = 1'b0; bus_a.rd = 1'b0;
        tick();
        tests_run++; if (bus_a.rdata_valid !== 1'b0) begin tests_failed++; $display("FAIL read_valid_drop got %b want 0", bus_a.rdata_valid); end
        tests_run++; if (bus_a.rdata !== 8'h5A) begin tests_failed++; $display("FAIL read_rdata_kept got %h want 5A", bus_a.rdata); end
    endtask

    task automatic test_write_wrap();
        int reqs;
        bus_b.segment = 8'hFF; bus_b.addr = 16'h3FFF; bus_b.size = 8'h00; bus_b.wdata = 8'hA5;
        bus_b.rd = 1'b0; bus_b.wr = 1'b1; bus_b.mem_rq = 1'b1;
        #1;
        tests_run++; if (bus_b.cpu_wait !== 1'b1) begin tests_failed++; $display("FAIL write_start_wait got %b want 1", bus_b.cpu_wait); end
        tick();
        reqs = bus_b.ram_req ? 1 : 0;
        tests_run++; if (bus_b.ram_addr !== 22'h3EFFFF) begin tests_failed++; $display("FAIL write_ram_addr got %h want 3EFFFF", bus_b.ram_addr); end
        tests_run++; if (bus_b.ram_we !== 1'b1) begin tests_failed++; $display("FAIL write_ram_we got %b want 1", bus_b.ram_we); end
        tests_run++; if (bus_b.ram_wdata !== 8'hA5) begin tests_failed++; $display("FAIL write_ram_wdata got %h want A5", bus_b.ram_wdata); end
        bus_b.ram_ack = 1'b1;
        tick();
        bus_b.ram_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus_b.ram_req) reqs++;
            tick();
        end
        tests_run++; if (reqs != 1) begin tests_failed++; $display("FAIL write_req_cycles got %0d want 1", reqs); end
        tests_run++; if (bus_b.rdata_valid !== 1'b0 || bus_b.cpu_wait !== 1'b0) begin tests_failed++; $display("FAIL write_done got valid=%b wait=%b want 0/0", bus_b.rdata_valid, bus_b.cpu_wait); end
        bus_b.mem_rq = 1'b0; bus_b.wr = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range();
        int reqs;
        bus_a.segment = 8'h06; bus_a.addr = 16'h4000; bus_a.size = 8'h06;
        bus_a.rd = 1'b1; bus_a.wr = 1'b0; bus_a.mem_rq = 1'b1;
        #1;
        tests_run++; if (bus_a.cpu_wait !== 1'b1) begin tests_failed++; $display("FAIL oor_start_wait got %b want 1", bus_a.cpu_wait); end
        tick();
        tests_run++; if (bus_a.cpu_wait !== 1'b0) begin tests_failed++; $display("FAIL oor_wait_len got %b want 0", bus_a.cpu_wait); end
        tests_run++; if (bus_a.rdata !== 8'hFF || bus_a.rdata_valid !== 1'b1) begin tests_failed++; $display("FAIL oor_read got rdata=%h valid=%b want FF/1", bus_a.rdata, bus_a.rdata_valid); end
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_a.ram_req) reqs++;
            tick();
        end
        tests_run++; if (reqs != 0) begin tests_failed++; $display("FAIL oor_read_req got %0d want 0", reqs); end
        drop_a();
        bus_a.rd = 1'b0; bus_a.wr = 1'b1; bus_a.wdata = 8'h11; bus_a.mem_rq = 1'b1;
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_a.ram_req) reqs++;
        end
        tests_run++; if (reqs != 0) begin tests_failed++; $display("FAIL oor_write_req got %0d want 0", reqs); end
        tests_run++; if (bus_a.rdata_valid !== 1'b0) begin tests_failed++; $display("FAIL oor_write_valid got %b want 0", bus_a.rdata_valid); end
        drop_a();
    endtask

    task automatic test_back_to_back();
        int reqs;
        bus_a.segment = 8'h02; bus_a.addr = 16'h4010; bus_a.size = 8'h00; bus_a.wdata = 8'h22;
        bus_a.rd = 1'b1; bus_a.wr = 1'b1; bus_a.mem_rq = 1'b1;
        tick();
        reqs = bus_a.ram_req ? 1 : 0;
        tests_run++; if (bus_a.ram_we !== 1'b0) begin tests_failed++; $display("FAIL rdwr_ram_we got %b want 0", bus_a.ram_we); end
        tests_run++; if (bus_a.ram_addr !== 22'h008010) begin tests_failed++; $display("FAIL rdwr_ram_addr got %h want 008010", bus_a.ram_addr); end
        bus_a.ram_rdata = 8'h3C; bus_a.ram_ack = 1'b1;
        tick();
        bus_a.ram_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus_a.ram_req) reqs++;
            tick();
        end
        tests_run++; if (reqs != 1) begin tests_failed++; $display("FAIL hold_req_pulses got %0d want 1", reqs); end
        tests_run++; if (bus_a.rdata !== 8'h3C || bus_a.rdata_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_rdata got %h valid=%b want 3C/1", bus_a.rdata, bus_a.rdata_valid); end
        drop_a();
    endtask

    task automatic test_timeout();
        int reqs;
        bus_a.segment = 8'h01; bus_a.addr = 16'h4000; bus_a.size = 8'h00;
        bus_a.rd = 1'b1; bus_a.wr = 1'b0; bus_a.mem_rq = 1'b1;
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_a.ram_req) reqs++;
            else break;
        end
        tests_run++; if (reqs != 4) begin tests_failed++; $display("FAIL timeout_req_cycles got %0d want 4", reqs); end
        tests_run++; if (bus_a.rdata !== 8'hFF) begin tests_failed++; $display("FAIL timeout_rdata got %h want FF", bus_a.rdata); end
        tests_run++; if (bus_a.timeout_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_err got %b want 1", bus_a.timeout_err); end
        tests_run++; if (bus_a.rdata_valid !== 1'b1 || bus_a.cpu_wait !== 1'b0) begin tests_failed++; $display("FAIL timeout_done got valid=%b wait=%b want 1/0", bus_a.rdata_valid, bus_a.cpu_wait); end
    endtask

    task automatic test_late_ack();
        bus_a.ram_rdata = 8'h77; bus_a.ram_ack = 1'b1;
        tick();
        bus_a.ram_ack = 1'b0;
        tests_run++; if (bus_a.rdata !== 8'hFF) begin tests_failed++; $display("FAIL late_ack_done got %h want FF", bus_a.rdata); end
        bus_a.mem_rq = 1'b0; bus_a.rd = 1'b0;
        tick();
        tick();
        bus_a.ram_ack = 1'b1;
        tick();
        bus_a.ram_ack = 1'b0;
        tests_run++; if (bus_a.rdata !== 8'hFF) begin tests_failed++; $display("FAIL late_ack_idle got %h want FF", bus_a.rdata); end
        tests_run++; if (bus_a.timeout_err !== 1'b1) begin tests_failed++; $display("FAIL sticky_err got %b want 1", bus_a.timeout_err); end
        tests_run++; if (bus_a.ram_req !== 1'b0) begin tests_failed++; $display("FAIL late_ack_req got %b want 0", bus_a.ram_req); end
    endtask

    task automatic test_reset_in_req();
        bus_a.segment = 8'h00; bus_a.addr = 16'h0001; bus_a.size = 8'h00;
        bus_a.rd = 1'b1; bus_a.wr = 1'b0; bus_a.mem_rq = 1'b1;
        tick();
        tests_run++; if (bus_a.ram_req !== 1'b1) begin tests_failed++; $display("FAIL rst_req_before got %b want 1", bus_a.ram_req); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (bus_a.ram_req !== 1'b0 || bus_a.cpu_wait !== 1'b0) begin tests_failed++; $display("FAIL rst_in_req got req=%b wait=%b want 0/0", bus_a.ram_req, bus_a.cpu_wait); end
        tests_run++; if (bus_a.timeout_err !== 1'b0) begin tests_failed++; $display("FAIL rst_err_clear got %b want 0", bus_a.timeout_err); end
        bus_a.mem_rq = 1'b0; bus_a.rd = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        bus_a.rd = 1'b1; bus_a.mem_rq = 1'b1;
        tick();
        tests_run++; if (bus_a.ram_req !== 1'b1 || bus_a.ram_addr !== 22'h000001) begin tests_failed++; $display("FAIL rst_new_req got req=%b addr=%h want 1/000001", bus_a.ram_req, bus_a.ram_addr); end
        bus_a.ram_rdata = 8'h99; bus_a.ram_ack = 1'b1;
        tick();
        bus_a.ram_ack = 1'b0;
        tests_run++; if (bus_a.rdata !== 8'h99 || bus_a.rdata_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_new_read got %h valid=%b want 99/1", bus_a.rdata, bus_a.rdata_valid); end
        tests_run++; if (bus_a.timeout_err !== 1'b0) begin tests_failed++; $display("FAIL rst_new_err got %b want 0", bus_a.timeout_err); end
        drop_a();
    endtask

    initial begin
        reset_n = 1'b0;
        bus_a.mem_rq = 1'b0; bus_a.rd = 1'b0; bus_a.wr = 1'b0; bus_a.addr = '0;
        bus_a.wdata = '0; bus_a.segment = '0; bus_a.size = '0; bus_a.ram_ack = 1'b0; bus_a.ram_rdata = '0;
        bus_b.mem_rq = 1'b0; bus_b.rd = 1'b0; bus_b.wr = 1'b0; bus_b.addr = '0;
        bus_b.wdata = '0; bus_b.segment = '0; bus_b.size = '0; bus_b.ram_ack = 1'b0; bus_b.ram_rdata = '0;
        tick();
        tick();
        test_reset();
        reset_n = 1'b1;
        tick();
        test_read();
        test_write_wrap();
        test_out_of_range();
        test_back_to_back();
        test_timeout();
        test_late_ack();
        test_reset_in_req();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d tests", tests_run);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msx2_ram_mapper_bridge.md
Name: msx2_ram_mapper_bridge

Overview:
- Memory-side counterpart of the MSX2 mapper segment registers (I/O ports FC–FF).
- Takes the CPU memory cycle plus the segment number selected by addr[15:14], forms the physical RAM address, and runs a req/ack handshake with the RAM controller.
- Stretches the CPU cycle with wait and holds read data for the CPU data mux.
- Sits between the slot decoder / mapper register block and the shared RAM arbiter.

Parameters:
- ADDR_W, 22, physical RAM address width (8-bit segment + 14-bit offset).
- RAM_BASE, 22'h000000, base offset added to the mapped address (ADDR_W bits).
- TIMEOUT, 255, cycles spent in REQ without ram_ack before the access is aborted (1..255).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mem_rq  in  1  CPU memory cycle decoded to this mapper slot (mreq & slot hit)
- rd  in  1  CPU read strobe
- wr  in  1  CPU write strobe
- addr  in  16  CPU address
- wdata  in  8  CPU write data
- segment  in  8  segment number for addr[15:14], already masked by the register block
- size  in  8  mapper size in 16 KB segments; 0 means 256
- cpu_wait  out  1  high stretches the CPU cycle
- rdata  out  8  read data to the CPU data mux
- rdata_valid  out  1  rdata is valid for the current read cycle
- ram_req  out  1  request to the RAM controller
- ram_we  out  1  1 = write, 0 = read; valid while ram_req is high
- ram_addr  out  ADDR_W  physical byte address
- ram_wdata  out  8  write data
- ram_ack  in  1  controller accepted/completed the access; ram_rdata is valid in the same cycle for reads
- ram_rdata  in  8  read data from the RAM controller
- timeout_err  out  1  sticky; set on any aborted access

Behaviour:
- Reset (async, reset_n low) sets:
  - state = IDLE
  - cpu_wait = 0, rdata = 8'hFF, rdata_valid = 0
  - ram_req = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0
  - timeout counter = 0, timeout_err = 0
- start = state==IDLE & mem_rq & (rd | wr). If rd and wr are both high, the access is treated as a read; no write is ever issued in that case.
- On start, latch addr[13:0], segment, wdata and the direction (we = wr & ~rd).
  - cpu_wait is asserted combinationally in the start cycle, so the CPU sees wait with zero latency.
- Out of range: size != 0 and segment >= size.
  - No RAM request is issued. The FSM goes directly to DONE.
  - A read returns 8'hFF; a write is dropped.
- Address: ram_addr = RAM_BASE + {segment, addr[13:0]}, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
- FSM states:
  - IDLE: start & in range -> REQ; start & out of range -> DONE.
  - REQ:
    - ram_req = 1; ram_we, ram_addr and ram_wdata are stable from the first REQ cycle until ack.
    - cpu_wait = 1.
    - ram_ack high -> DONE. On a read, rdata <= ram_rdata on that edge.
    - Otherwise the counter increments. When counter == TIMEOUT-1 and there is no ack: go to DONE, rdata <= FF, timeout_err <= 1.
    - ram_ack in the first REQ cycle gives minimum latency: 1 cycle of ram_req, 2 cycles of cpu_wait including the start cycle.
  - DONE:
    - ram_req = 0, cpu_wait = 0.
    - rdata_valid = 1 if the access was a read.
    - Stays in DONE while mem_rq is high; mem_rq low -> IDLE and the counter is cleared.
- Exactly one RAM access is issued per CPU cycle; holding mem_rq high never re-triggers.
- ram_ack seen in IDLE or DONE (late ack after a timeout) is ignored and rdata is unchanged.
- mem_rq dropping while in REQ (CPU abort): the request stays held until ack or timeout, then DONE -> IDLE on the next cycle. The handshake is never abandoned mid-transfer except by reset.
- Reset during REQ drops ram_req immediately; the controller must tolerate a withdrawn request.
- rdata holds its last value outside DONE. Only rdata_valid qualifies it.

Decomposition:
- Shared MSX package holds:
  - mapper_bridge_state_t (IDLE, REQ, DONE)
  - SEG_OFFSET_W = 14
  - the open-bus constant 8'hFF
- One natural sub-module: msx2_ram_req_timer (timeout counter with clear/enable/expire).
- The address formation and the FSM stay in the top module.

Test Plan:
- Read, segment=8'h03, addr=16'h8123, size=8'h08, ram_ack on the 3rd REQ cycle, ram_rdata=8'h5A:
  - ram_addr = 22'h00C123, ram_we=0
  - cpu_wait high for 4 cycles
  - rdata=5A and rdata_valid=1 in DONE until mem_rq drops.
- Write, segment=8'hFF, addr=16'h3FFF, size=0, RAM_BASE=22'h3F0000, wdata=8'hA5, ack on the first REQ cycle:
  - ram_addr wraps to 22'h3EFFFF, ram_we=1, ram_wdata=A5
  - exactly one ram_req cycle.
- Out of range, size=8'h06, segment=8'h06, read:
  - no ram_req, rdata=FF next cycle, cpu_wait for 1 cycle only.
  - The same case as a write produces no ram_req.
- Timeout, TIMEOUT=4, ram_ack never asserted:
  - ram_req high for 4 cycles, then DONE with rdata=FF and timeout_err=1.
  - A late ack afterwards leaves rdata=FF; timeout_err stays set until reset.
- mem_rq held high for 20 cycles after ack: exactly one ram_req pulse.
  - rd and wr both high gives ram_we=0.
- reset_n pulsed low during REQ: ram_req=0 and cpu_wait=0 immediately.
  - After release, a new read completes normally with timeout_err=0.
